// File: rtl/ysyx_23060208_isram.sv
// Instruction SRAM slave on the fetch AR/R read channel. One outstanding read,
// with a fixed or LFSR-driven response latency and a side preload port.
module ysyx_23060208_isram #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  DEPTH      = 4096,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 32'h80000000,
    parameter int                  RAND_LAT   = 1,
    parameter int                  FIXED_LAT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    isram_araddr,
    input  logic                     isram_arvalid,
    output logic                     isram_arready,
    output logic [DATA_WIDTH-1:0]    isram_rdata,
    output logic                     isram_rvalid,
    output logic [1:0]               isram_rresp,
    input  logic                     isram_rready,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [DATA_WIDTH-1:0]    ld_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH:0] SPAN = (DATA_WIDTH+1)'(4 * DEPTH);

    // Handshake rules: an AR transfer happens on a rising edge where
    // arvalid && arready; an R transfer on an edge where rvalid && rready.
    // arready is high only in IDLE, rvalid only in RESP, so the two transfers
    // can never share an edge and at most one read is in flight.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [2:0]            cnt, cnt_n;
    logic [7:0]            lfsr;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  capture;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] offset;
    logic                  misaligned;
    logic                  in_range;
    logic [AW-1:0]         word_idx;
    logic [2:0]            lat_m1;
    logic [DATA_WIDTH-1:0] rdata_c;
    logic [1:0]            rresp_c;

    always_comb begin
        offset     = isram_araddr - BASE_ADDR;
        misaligned = |isram_araddr[1:0];
        in_range   = (isram_araddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        word_idx   = offset[AW+1:2];
        // Latency minus one: 0 means data is presented right after the AR edge.
        lat_m1     = (RAND_LAT != 0) ? lfsr[2:0] : 3'(FIXED_LAT - 1);
        rdata_c    = '0;
        rresp_c    = 2'b00;
        if (misaligned) begin
            rresp_c = 2'b10;
        end else if (!in_range) begin
            rresp_c = 2'b11;
        end else begin
            rdata_c = mem[word_idx];
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (isram_arvalid) begin
                    capture = 1'b1;
                    if (lat_m1 == 3'd0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = lat_m1;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 3'd1) begin
                    state_n = RESP;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            RESP: begin
                if (isram_rready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            lfsr    <= 8'hA5;
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (capture) begin
                rdata_q <= rdata_c;
                rresp_q <= rresp_c;
            end
        end
    end

    // The capture above reads the pre-edge array, so a same-edge preload to
    // the fetched word returns the old contents.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    assign isram_arready = (state == IDLE);
    assign isram_rvalid  = (state == RESP);
    assign isram_rdata   = rdata_q;
    assign isram_rresp   = rresp_q;

    function void get_isram_rvalid(output bit rvalid_o);
        rvalid_o = isram_rvalid;
    endfunction

endmodule
